serial_rx_unit: RTL and testbench
=================================

Name: serial_rx_unit

Overview:
- Synthesizable UART receiver for the board's serial input pin; mirror of the design's serial transmitter (8N1, LSB first, idle high).
- Deserializes IN_SERIAL_RX into bytes and presents them to the command/game logic through a one-byte valid/ready holding register.
- Flags framing errors and overruns.
- Sits directly behind the top-level IN_SERIAL_RX pin; clocked by the 25 MHz system clock.

Parameters:
- CLKS_PER_BIT, 217, system clocks per bit (25 MHz / 115200); legal range 4..65535.
- HALF_BIT, CLKS_PER_BIT/2 (integer divide), clocks from start-edge detect to start-bit sample; derived, never overridden.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- IN_SERIAL_RX  in  1  asynchronous serial line, idle high.
- RX_DATA  out  8  received byte; stable while RX_VALID=1.
- RX_VALID  out  1  holding register full.
- RX_READY  in  1  consumer accepts; transfer occurs when RX_VALID & RX_READY at a rising edge.
- RX_FRAME_ERR  out  1  one-cycle pulse, stop bit sampled low.
- RX_OVERRUN  out  1  one-cycle pulse, new byte dropped because the holding register was full.
- RX_BUSY  out  1  high in any state other than IDLE.

Behaviour:
- Reset (sync, active-high): state=IDLE, both synchronizer flops=1, bit counter=0, clock counter=0, shift register=0, RX_DATA=8'h00, RX_VALID=0, RX_FRAME_ERR=0, RX_OVERRUN=0, RX_BUSY=0.
- RESET asserted mid-frame aborts the frame; no partial byte is ever delivered.
- Input path: 2-FF synchronizer, output rx_s. All decisions use rx_s only.
- States: IDLE, START, DATA, STOP, BREAK.
- Clock counter: 16 bits, cleared on every state entry.
- IDLE: when rx_s=0, go to START.
- START: at count HALF_BIT-1, sample rx_s.
  - rx_s=1: glitch; return to IDLE, no flags.
  - rx_s=0: go to DATA with bit index 0.
- DATA: at count CLKS_PER_BIT-1, sample rx_s into shift[bit index] (LSB first) and clear the counter.
  - After index 7, go to STOP.
- STOP: at count CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1: deliver the byte (see below) and go to IDLE in the same cycle, so back-to-back frames need no extra idle time.
  - rx_s=0: pulse RX_FRAME_ERR, discard the byte, go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from being read as repeated 8'h00 frames.
- Delivery, evaluated on the stop-sample cycle:
  - If RX_VALID=0, or RX_VALID&RX_READY in that same cycle: load RX_DATA and set RX_VALID=1 on the next edge. The simultaneous consume-and-load case loses no byte.
  - Otherwise: keep the old byte, pulse RX_OVERRUN.
- RX_VALID clears on a transfer unless a new byte loads in the same cycle.
- Latency: RX_VALID rises HALF_BIT + 9*CLKS_PER_BIT + 2 (synchronizer) + 1 clocks after the falling start edge reaches the pin register.
- Pulses: RX_FRAME_ERR and RX_OVERRUN are registered, exactly one cycle wide, and never asserted together for the same frame.

Optional Feature:
- Macro: SERIAL_RX_PARITY_EN.
- When defined:
  - A PARITY state sits between DATA and STOP and is sampled at CLKS_PER_BIT-1. Frames are 8E1 (even parity).
  - Adds output port RX_PARITY_ERR (1 bit), a one-cycle pulse on the stop-sample cycle when the XOR of the 8 data bits and the parity bit is 1.
  - A byte with a parity error is still delivered (subject to the overrun rule).
  - Latency grows by CLKS_PER_BIT.
- When undefined: no PARITY state, no RX_PARITY_ERR port; 8N1 only.

Test Plan:
- CLKS_PER_BIT=8; send 8'hA5 framed 8N1 with RX_READY=1 -> RX_VALID high for exactly 1 cycle, RX_DATA=8'hA5 at latency 4+72+3 clocks from the start edge; no error pulses.
- RX_READY=0; send 8'h3C then 8'hC3 back-to-back -> RX_DATA stays 8'h3C, RX_VALID stays 1, one RX_OVERRUN pulse at the second stop sample. Then raise RX_READY -> RX_VALID drops next cycle.
- Send 8'h55 with the stop bit forced low, then hold the line low for 40 clocks, then release -> one RX_FRAME_ERR pulse, no RX_VALID, RX_BUSY stays high until the line returns high. A following 8'h12 is received correctly.
- 2-clock low glitch on an idle line -> back to IDLE after the START sample, RX_BUSY high for HALF_BIT cycles, no flags, no RX_VALID.
- Assert RESET during data bit 4 of 8'hFF, release, then send 8'h81 -> only 8'h81 delivered, all outputs at reset values while RESET is high.
- With SERIAL_RX_PARITY_EN: send 8'h07 with parity bit 0 -> RX_DATA=8'h07, one RX_PARITY_ERR pulse. With parity bit 1 -> no pulse.

Source files
------------

// File: rtl/serial_rx_unit.sv
// serial_rx_unit: UART receiver (8N1, LSB first, idle high) for the board's
// serial input pin. Received bytes are handed to the consumer through a
// one-byte valid/ready holding register. Framing errors and overruns are
// reported as one-cycle pulses.
//
// Optional build macro SERIAL_RX_PARITY_EN: frames become 8E1, a PARITY
// state is inserted between DATA and STOP, and the RX_PARITY_ERR port is added.
//
// Ports:
//   CLK           in   system clock, rising edge
//   RESET         in   synchronous active-high reset
//   IN_SERIAL_RX  in   asynchronous serial line, idle high
//   RX_DATA       out  received byte, stable while RX_VALID=1
//   RX_VALID      out  holding register full
//   RX_READY      in   consumer accepts (transfer when RX_VALID & RX_READY)
//   RX_FRAME_ERR  out  one-cycle pulse, stop bit sampled low
//   RX_OVERRUN    out  one-cycle pulse, byte dropped because register was full
//   RX_PARITY_ERR out  (SERIAL_RX_PARITY_EN only) one-cycle parity-error pulse
//   RX_BUSY       out  receiver not idle
module serial_rx_unit #(
  parameter int CLKS_PER_BIT = 217
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       IN_SERIAL_RX,
  output logic [7:0] RX_DATA,
  output logic       RX_VALID,
  input  logic       RX_READY,
  output logic       RX_FRAME_ERR,
  output logic       RX_OVERRUN,
`ifdef SERIAL_RX_PARITY_EN
  output logic       RX_PARITY_ERR,
`endif
  output logic       RX_BUSY
);

  localparam int          HALF_BIT  = CLKS_PER_BIT / 2;
  localparam logic [15:0] HALF_LAST = 16'(HALF_BIT - 1);
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
`ifdef SERIAL_RX_PARITY_EN
    , PARITY
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  data_q, data_d;
  logic        valid_q, valid_d;
  logic        frame_err_q, frame_err_d;
  logic        overrun_q, overrun_d;
  logic        rx_s;
`ifdef SERIAL_RX_PARITY_EN
  logic        parity_bit_q, parity_bit_d;
  logic        parity_err_q, parity_err_d;
`endif

  assign rx_s = sync2_q;

  // Next-state logic. The clock counter free-runs and is cleared whenever a
  // state is entered (or a data bit is sampled), so each compare is relative
  // to the last event. IDLE and BREAK hold the counter at zero.
  always_comb begin
    sync1_d     = IN_SERIAL_RX;
    sync2_d     = sync1_q;
    state_d     = state_q;
    cnt_d       = cnt_q + 16'd1;
    bit_idx_d   = bit_idx_q;
    shift_d     = shift_q;
    data_d      = data_q;
    // A transfer empties the register unless a new byte loads below.
    valid_d     = valid_q & ~RX_READY;
    frame_err_d = 1'b0;
    overrun_d   = 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    parity_bit_d = parity_bit_q;
    parity_err_d = 1'b0;
`endif

    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!rx_s) state_d = START;
      end

      START: begin
        if (cnt_q == HALF_LAST) begin
          cnt_d = '0;
          if (rx_s) begin
            // Line went back high before mid start bit: treat as a glitch.
            state_d = IDLE;
          end else begin
            state_d   = DATA;
            bit_idx_d = 3'd0;
          end
        end
      end

      DATA: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_idx_q] = rx_s;
          bit_idx_d        = bit_idx_q + 3'd1;
          if (bit_idx_q == 3'd7) begin
`ifdef SERIAL_RX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end
      end

`ifdef SERIAL_RX_PARITY_EN
      PARITY: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d        = '0;
          parity_bit_d = rx_s;
          state_d      = STOP;
        end
      end
`endif

      STOP: begin
        if (cnt_q == BIT_LAST) begin
          cnt_d = '0;
`ifdef SERIAL_RX_PARITY_EN
          parity_err_d = (^shift_q) ^ parity_bit_q;
`endif
          if (rx_s) begin
            // Return to IDLE immediately so back-to-back frames are caught.
            state_d = IDLE;
            if (!valid_q || RX_READY) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              overrun_d = 1'b1;
            end
          end else begin
            frame_err_d = 1'b1;
            state_d     = BREAK;
          end
        end
      end

      BREAK: begin
        // Wait out a held-low line so it is not decoded as repeated 0x00.
        cnt_d = '0;
        if (rx_s) state_d = IDLE;
      end

      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= IDLE;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      cnt_q       <= '0;
      bit_idx_q   <= '0;
      shift_q     <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
      parity_bit_q <= 1'b0;
      parity_err_q <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      sync2_q     <= sync2_d;
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
`ifdef SERIAL_RX_PARITY_EN
      parity_bit_q <= parity_bit_d;
      parity_err_q <= parity_err_d;
`endif
    end
  end

  assign RX_DATA      = data_q;
  assign RX_VALID     = valid_q;
  assign RX_FRAME_ERR = frame_err_q;
  assign RX_OVERRUN   = overrun_q;
  assign RX_BUSY      = (state_q != IDLE);
`ifdef SERIAL_RX_PARITY_EN
  assign RX_PARITY_ERR = parity_err_q;
`endif

endmodule

// File: tb/tb_serial_rx_unit.sv
// tb_serial_rx_unit: self-checking bench for serial_rx_unit with CLKS_PER_BIT=8.
// A frame-level scoreboard predicts, for every frame sent, what the holding
// register and the error pulses must do on the stop-sample cycle; a compare
// process checks the DUT against it on every cycle after reset. Directed
// checks with hand-computed literals pin latency, data and pulse counts.
// Builds with or without SERIAL_RX_PARITY_EN.
module tb_serial_rx_unit;

  localparam int C = 8;
  localparam int H = C / 2;
`ifdef SERIAL_RX_PARITY_EN
  localparam int LAT     = H + 10 * C + 3;
  localparam int EXP_LAT = 87;
`else
  localparam int LAT     = H + 9 * C + 3;
  localparam int EXP_LAT = 79;
`endif

  logic       clk;
  logic       reset;
  logic       rx_pin;
  logic       rx_ready;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_frame_err;
  logic       rx_overrun;
  logic       rx_busy;
`ifdef SERIAL_RX_PARITY_EN
  logic       rx_parity_err;
`endif

  serial_rx_unit #(.CLKS_PER_BIT(C)) dut (
    .CLK          (clk),
    .RESET        (reset),
    .IN_SERIAL_RX (rx_pin),
    .RX_DATA      (rx_data),
    .RX_VALID     (rx_valid),
    .RX_READY     (rx_ready),
    .RX_FRAME_ERR (rx_frame_err),
    .RX_OVERRUN   (rx_overrun),
`ifdef SERIAL_RX_PARITY_EN
    .RX_PARITY_ERR(rx_parity_err),
`endif
    .RX_BUSY      (rx_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // Frame scoreboard: each entry says on which clock edge the stop bit is
  // sampled and what must happen there.
  typedef struct {
    int unsigned at;
    logic [7:0]  b;
    bit          stop_ok;
    bit          pbad;
  } ev_t;
  ev_t evq[$];

  int unsigned cyc = 0;
  logic       m_valid, m_fe, m_ov;
  logic [7:0] m_data;
`ifdef SERIAL_RX_PARITY_EN
  logic       m_pe;
`endif

  // Abstract holding-register model driven by the scoreboard.
  always @(posedge clk) begin
    cyc  <= cyc + 1;
    m_fe <= 1'b0;
    m_ov <= 1'b0;
`ifdef SERIAL_RX_PARITY_EN
    m_pe <= 1'b0;
`endif
    if (reset) begin
      m_valid <= 1'b0;
      m_data  <= 8'h00;
      evq.delete();
    end else if (evq.size() > 0 && evq[0].at == cyc + 1) begin
      if (evq[0].stop_ok) begin
        if (!m_valid || rx_ready) begin
          m_data  <= evq[0].b;
          m_valid <= 1'b1;
        end else begin
          m_ov <= 1'b1;
        end
      end else begin
        m_fe <= 1'b1;
        if (m_valid && rx_ready) m_valid <= 1'b0;
      end
`ifdef SERIAL_RX_PARITY_EN
      m_pe <= evq[0].pbad;
`endif
      void'(evq.pop_front());
    end else if (m_valid && rx_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Pulse and delivery counters observed on the DUT side.
  int         n_fe = 0, n_ov = 0, n_vld = 0, n_pe = 0;
  logic [7:0] last_data = 8'h00;
  always @(negedge clk) begin
    if (rx_frame_err === 1'b1) n_fe <= n_fe + 1;
    if (rx_overrun === 1'b1)   n_ov <= n_ov + 1;
    if (rx_valid === 1'b1) begin
      n_vld     <= n_vld + 1;
      last_data <= rx_data;
    end
`ifdef SERIAL_RX_PARITY_EN
    if (rx_parity_err === 1'b1) n_pe <= n_pe + 1;
`endif
  end

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)",
               name, act, exp, cyc);
    end
  endtask

  // Sends one frame starting at the current negedge; returns at the negedge
  // where the next frame's start bit may begin.
  task automatic applyStimulus(input logic [7:0] b, input bit stop_bit,
                               input bit par_flip);
    evq.push_back(ev_t'{cyc + LAT, b, stop_bit, par_flip});
    rx_pin = 1'b0;
    repeat (C) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rx_pin = b[i];
      repeat (C) @(negedge clk);
    end
`ifdef SERIAL_RX_PARITY_EN
    rx_pin = (^b) ^ par_flip;
    repeat (C) @(negedge clk);
`endif
    rx_pin = stop_bit;
    repeat (C) @(negedge clk);
  endtask

  // Every-cycle comparison against the scoreboard model.
  always @(negedge clk) begin
    if (chk_en) begin
      checkOutput("valid", 32'(rx_valid), 32'(m_valid));
      checkOutput("data", 32'(rx_data), 32'(m_data));
      checkOutput("frame_err", 32'(rx_frame_err), 32'(m_fe));
      checkOutput("overrun", 32'(rx_overrun), 32'(m_ov));
`ifdef SERIAL_RX_PARITY_EN
      checkOutput("parity_err", 32'(rx_parity_err), 32'(m_pe));
`endif
    end
  end

  int         lat;
  logic [7:0] lat_data;
  logic       valid_after;
  int         fe0, ov0, vld0, pe0, busy_cnt;

  initial begin
    reset    = 1'b1;
    rx_pin   = 1'b1;
    rx_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    checkOutput("reset_busy", 32'(rx_busy), 32'd0);
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_data", 32'(rx_data), 32'h00);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // Single byte with the consumer always ready.
    fe0 = n_fe; ov0 = n_ov;
    fork
      applyStimulus(8'hA5, 1'b1, 1'b0);
      begin
        lat = 0;
        while (rx_valid !== 1'b1 && lat < 300) begin
          @(negedge clk);
          lat++;
        end
        lat_data = rx_data;
        @(negedge clk);
        valid_after = rx_valid;
      end
    join
    repeat (2) @(negedge clk);
    checkOutput("a5_latency", 32'(lat), 32'(EXP_LAT));
    checkOutput("a5_data", 32'(lat_data), 32'hA5);
    checkOutput("a5_valid_one_cycle", 32'(valid_after), 32'd0);
    checkOutput("a5_no_fe", 32'(n_fe - fe0), 32'd0);
    checkOutput("a5_no_ov", 32'(n_ov - ov0), 32'd0);

    // Overrun: consumer stalled, two back-to-back frames.
    rx_ready = 1'b0;
    fe0 = n_fe; ov0 = n_ov;
    applyStimulus(8'h3C, 1'b1, 1'b0);
    applyStimulus(8'hC3, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("ovr_valid_held", 32'(rx_valid), 32'd1);
    checkOutput("ovr_data_kept", 32'(rx_data), 32'h3C);
    checkOutput("ovr_pulses", 32'(n_ov - ov0), 32'd1);
    checkOutput("ovr_no_fe", 32'(n_fe - fe0), 32'd0);
    rx_ready = 1'b1;
    @(negedge clk);
    checkOutput("ovr_drain", 32'(rx_valid), 32'd0);

    // Framing error followed by a held-low line, then a clean byte.
    fe0 = n_fe; ov0 = n_ov; vld0 = n_vld;
    applyStimulus(8'h55, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    checkOutput("break_busy", 32'(rx_busy), 32'd1);
    rx_pin = 1'b1;
    repeat (6) @(negedge clk);
    checkOutput("break_exit_busy", 32'(rx_busy), 32'd0);
    checkOutput("fe_pulses", 32'(n_fe - fe0), 32'd1);
    checkOutput("fe_no_valid", 32'(n_vld - vld0), 32'd0);
    checkOutput("fe_no_ov", 32'(n_ov - ov0), 32'd0);
    vld0 = n_vld;
    applyStimulus(8'h12, 1'b1, 1'b0);
    repeat (4) @(negedge clk);
    checkOutput("after_break_count", 32'(n_vld - vld0), 32'd1);
    checkOutput("after_break_data", 32'(last_data), 32'h12);

    // Two-clock glitch on an idle line.
    fe0 = n_fe; ov0 = n_ov; vld0 = n_vld;
    rx_pin = 1'b0;
    repeat (2) @(negedge clk);
    rx_pin = 1'b1;
    busy_cnt = 0;
    repeat (18) begin
      @(negedge clk);
      if (rx_busy === 1'b1) busy_cnt++;
    end
    checkOutput("glitch_busy_cycles", 32'(busy_cnt), 32'd4);
    checkOutput("glitch_no_valid", 32'(n_vld - vld0), 32'd0);
    checkOutput("glitch_no_flags", 32'(n_fe - fe0 + n_ov - ov0), 32'd0);

    // Reset during data bit 4 of 0xFF, then a clean 0x81.
    vld0 = n_vld;
    fork
      applyStimulus(8'hFF, 1'b1, 1'b0);
      begin
        repeat (5 * C + C / 2) @(negedge clk);
        reset = 1'b1;
        repeat (3) begin
          @(negedge clk);
          checkOutput("rst_busy", 32'(rx_busy), 32'd0);
          checkOutput("rst_valid", 32'(rx_valid), 32'd0);
          checkOutput("rst_data", 32'(rx_data), 32'h00);
        end
        reset = 1'b0;
      end
    join
    repeat (5) @(negedge clk);
    applyStimulus(8'h81, 1'b1, 1'b0);
    repeat (5) @(negedge clk);
    checkOutput("post_reset_count", 32'(n_vld - vld0), 32'd1);
    checkOutput("post_reset_data", 32'(last_data), 32'h81);

`ifdef SERIAL_RX_PARITY_EN
    // 0x07 has three ones: parity bit 0 is wrong, parity bit 1 is right.
    pe0 = n_pe;
    applyStimulus(8'h07, 1'b1, 1'b1);
    repeat (3) @(negedge clk);
    checkOutput("par_bad_pulse", 32'(n_pe - pe0), 32'd1);
    checkOutput("par_bad_data", 32'(last_data), 32'h07);
    pe0 = n_pe;
    applyStimulus(8'h07, 1'b1, 1'b0);
    repeat (3) @(negedge clk);
    checkOutput("par_ok_pulse", 32'(n_pe - pe0), 32'd0);
`else
    pe0 = n_pe;
    checkOutput("no_parity_pulses", 32'(pe0), 32'd0);
`endif

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
